apg_shot_sequencer: RTL and testbench
=====================================

# apg_shot_sequencer

Single-clock controller that drives the AXI-side register interface of the arbitrary pattern generator (APG) without software in the loop. It clears the APG, loads a pattern from its own staging RAM with correctly spaced write strobes, and fires a programmable number of shots. After each shot it drains the APG read buffer into a capture RAM and counts masked mismatches against the loaded pattern, for loopback tests. It sits between the AXI register file and the APG, in the axi_clk domain.

## Interface
Parameters:
- NUM_SIG, 14, width of one sample; must equal the APG NUM_SIG.
- NUM_SAMP, 128, depth of the staging RAM, the capture RAM and the APG buffers.
- AW, 8, address width of the host RAM ports; AW ≥ clog2(NUM_SAMP).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - axi_clk  in  1  sole clock.
  - axi_resetn  in  1  asynchronous, active-low reset.
- Host control and configuration:
  - start  in  1  one-cycle request to begin a run.
  - abort  in  1  one-cycle request to stop the run.
  - n_samples_cfg  in  32  samples per shot.
  - n_shots  in  16  number of shots; 0 is treated as 1.
  - timeout_cycles  in  32  wait-state limit; 0 disables the timeout.
  - compare_mask  in  NUM_SIG  bits that take part in mismatch compare.
- Host RAM ports:
  - pat_wr_en  in  1  staging RAM write enable.
  - pat_wr_addr  in  AW  staging RAM write address.
  - pat_wr_data  in  NUM_SIG  staging RAM write data.
  - cap_rd_addr  in  AW  capture RAM read address.
  - cap_rd_data  out  NUM_SIG  capture RAM read data, registered.
- Host status:
  - busy  out  1  high in any state other than IDLE.
  - done  out  1  sticky; set on normal completion, cleared by the next accepted start.
  - shot_count  out  16  shots completed in the current run.
  - mismatch_count  out  32  masked mismatches, cumulative over the run; saturating.
  - err_flags  out  4  sticky: [0] config, [1] timeout, [2] abort, [3] APG dbg_error nonzero.
- APG side:
  - apg_run  out  1  one-cycle run pulse.
  - apg_clear  out  1  one-cycle clear pulse.
  - apg_n_samples  out  32  shot length driven to the APG.
  - apg_write_channel  out  NUM_SIG  sample being written.
  - apg_write_channel_wrStrobe  out  1  write strobe.
  - apg_read_channel_rdStrobe  out  1  read strobe.
  - apg_read_channel  in  NUM_SIG  APG read data.
  - apg_status  in  3  {triggered, state[1:0]}; state encoding IDLE=0, TRANSACTION=1, DONE=2.
  - apg_dbg_error  in  32  APG error word.

## Operation
- L = min(n_samples_cfg, NUM_SAMP), latched at start. apg_n_samples = L.
- States and transitions:
  - IDLE: start with L=0 sets err_flags[0] and stays in IDLE.
  - IDLE → CLEAR on accepted start. The accepted start clears done, shot_count, mismatch_count and err_flags[3:1].
  - CLEAR: apg_clear high for 1 cycle → LOAD.
  - LOAD: writes staging[0..L-1] in order → ARM.
  - ARM: apg_run high for 1 cycle → WAIT_DONE.
  - WAIT_DONE: waits until apg_status[1:0]==2 → WAIT_IDLE.
  - WAIT_IDLE: waits until apg_status==3'b000, then captures apg_read_channel as sample 0 → DRAIN.
  - DRAIN: reads samples 1..L-1 → NEXT.
  - NEXT: increments shot_count. If shot_count < n_shots → ARM; else set done → IDLE.
- The pattern is loaded once per run. Later shots reuse the APG write buffer.
- Each captured sample i is written to capture[i]. mismatch_count += 1 when (capture ^ staging[i]) & compare_mask != 0.
- apg_dbg_error nonzero in any state other than IDLE sets err_flags[3]. This is not fatal.
- Host writes to the staging RAM while busy=1 are ignored.
- cap_rd_addr ≥ NUM_SAMP returns 0.
- Abort:
  - abort in any state other than IDLE → IDLE in the next cycle with a 1-cycle apg_clear pulse. Sets err_flags[2]; done stays 0.
  - An abort issued in WAIT_DONE leaves the APG triggered; the host must reset the APG.
- Timeout: if timeout_cycles≠0 and WAIT_DONE or WAIT_IDLE lasts timeout_cycles cycles, the block behaves as for abort but sets err_flags[1] instead of err_flags[2].

## Timing
- Reset values: every output is 0. State is IDLE.
- Strobes are always single-cycle pulses with at least one low cycle between them, so the APG never flags a double strobe.
- LOAD:
  - Strobe sample i in cycle 2i.
  - apg_write_channel = staging[i], held through cycle 2i+1; the APG samples it at the end of cycle 2i+1.
  - LOAD takes 2L cycles.
- DRAIN:
  - rdStrobe in cycle k; capture apg_read_channel in cycle k+1; next strobe in k+2.
  - DRAIN takes 2(L-1) cycles.
- The staging RAM read has 1-cycle latency; fetches are pipelined so the cadences above hold exactly.
- Simultaneous events:
  - start and abort in the same cycle in IDLE: abort wins and nothing starts.
  - start while busy=1 is ignored.
  - abort takes priority over a timeout in the same cycle.
- Counters:
  - mismatch_count saturates at 2^32-1.
  - shot_count stops at n_shots.
- Reset asserted mid-run: the block returns to IDLE immediately and all outputs go to 0.

## Test plan
- Clean loopback: L=4, pattern 1,2,3,4, n_shots=1, APG inputs looped to outputs → wrStrobe pulses exactly 2 cycles apart, one apg_run pulse, capture[0..3]=1,2,3,4, mismatch_count=0, done=1, shot_count=1.
- Multi-shot with a stuck bit: n_shots=3, L=8, input bit 0 stuck at 0, pattern all 0x0001 → apg_run pulsed 3 times, mismatch_count=24. Repeat with compare_mask bit 0 cleared → mismatch_count=0.
- Configuration clamps: n_samples_cfg=0 → err_flags[0]=1, busy stays 0. n_samples_cfg=500 → L=128 and apg_n_samples=128.
- Timeout: APG status forced to 1 with timeout_cycles=50 → exactly 50 cycles in WAIT_DONE, then one apg_clear pulse, err_flags[1]=1, busy=0, done=0.
- Abort during DRAIN at sample 3 → IDLE next cycle, err_flags[2]=1, no further rdStrobe, shot_count unchanged.
- Protocol: check that no strobe is high in two consecutive cycles across a full run, and that apg_dbg_error stays 0 throughout.

Source files
------------

// File: rtl/apg_shot_sequencer.sv
// Standalone APG driver: clears the APG, loads a staged pattern, fires N shots and
// drains each shot's read buffer into a capture RAM while counting masked mismatches.
module apg_shot_sequencer #(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 128,
  parameter int AW       = 8
) (
  input  logic               axi_clk,
  input  logic               axi_resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        n_samples_cfg,
  input  logic [15:0]        n_shots,
  input  logic [31:0]        timeout_cycles,
  input  logic [NUM_SIG-1:0] compare_mask,
  input  logic               pat_wr_en,
  input  logic [AW-1:0]      pat_wr_addr,
  input  logic [NUM_SIG-1:0] pat_wr_data,
  input  logic [AW-1:0]      cap_rd_addr,
  output logic [NUM_SIG-1:0] cap_rd_data,
  output logic               busy,
  output logic               done,
  output logic [15:0]        shot_count,
  output logic [31:0]        mismatch_count,
  output logic [3:0]         err_flags,
  output logic               apg_run,
  output logic               apg_clear,
  output logic [31:0]        apg_n_samples,
  output logic [NUM_SIG-1:0] apg_write_channel,
  output logic               apg_write_channel_wrStrobe,
  output logic               apg_read_channel_rdStrobe,
  input  logic [NUM_SIG-1:0] apg_read_channel,
  input  logic [2:0]         apg_status,
  input  logic [31:0]        apg_dbg_error
);
  localparam int SW = $clog2(NUM_SAMP);
  localparam int LW = $clog2(NUM_SAMP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_ARM, S_WAIT_DONE, S_WAIT_IDLE, S_DRAIN, S_NEXT
  } state_e;

  state_e             state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic               ph_q, ph_d;
  logic [15:0]        nshot_q, nshot_d;
  logic [15:0]        shot_q, shot_d;
  logic [31:0]        wcnt_q, wcnt_d;
  logic [31:0]        mm_q, mm_d;
  logic [3:0]         err_q, err_d;
  logic               done_q, done_d;
  logic               kclr_q, kclr_d;

  logic [NUM_SIG-1:0] stage_mem [NUM_SAMP];
  logic [NUM_SIG-1:0] cap_mem   [NUM_SAMP];
  logic [NUM_SIG-1:0] pat_rd_q;
  logic [NUM_SIG-1:0] cap_rd_q;

  logic [LW-1:0]      rd_addr;
  logic               cap_we;
  logic [LW-1:0]      cap_waddr;
  logic [LW-1:0]      cfg_len;
  logic               wait_st, tmo, mm_hit;

  assign cfg_len = (n_samples_cfg > 32'(NUM_SAMP)) ? LW'(NUM_SAMP) : n_samples_cfg[LW-1:0];
  assign wait_st = (state_q == S_WAIT_DONE) || (state_q == S_WAIT_IDLE);
  assign tmo     = wait_st && (timeout_cycles != '0) && (wcnt_q + 32'd1 == timeout_cycles);
  assign mm_hit  = ((apg_read_channel ^ pat_rd_q) & compare_mask) != '0;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    ph_d      = ph_q;
    nshot_d   = nshot_q;
    shot_d    = shot_q;
    wcnt_d    = wait_st ? wcnt_q + 32'd1 : '0;
    mm_d      = mm_q;
    err_d     = err_q;
    done_d    = done_q;
    kclr_d    = 1'b0;
    rd_addr   = '0;
    cap_we    = 1'b0;
    cap_waddr = '0;
    case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          if (cfg_len == '0) begin
            err_d[0] = 1'b1;
          end else begin
            state_d    = S_CLEAR;
            len_d      = cfg_len;
            nshot_d    = (n_shots == '0) ? 16'd1 : n_shots;
            done_d     = 1'b0;
            shot_d     = '0;
            mm_d       = '0;
            err_d[3:1] = '0;
          end
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        ph_d    = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Odd cycle prefetches the next sample so it is on the bus at the next strobe.
        ph_d = ~ph_q;
        if (!ph_q) begin
          rd_addr = idx_q;
        end else begin
          rd_addr = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) state_d = S_ARM;
          else                         idx_d   = idx_q + LW'(1);
        end
      end
      S_ARM: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (apg_status[1:0] == 2'd2) begin
          state_d = S_WAIT_IDLE;
          wcnt_d  = '0;
        end
      end
      S_WAIT_IDLE: begin
        if (apg_status == 3'b000) begin
          cap_we = 1'b1;
          if (len_q == LW'(1)) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_DRAIN;
            idx_d   = LW'(1);
            ph_d    = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          rd_addr = idx_q;
        end else begin
          cap_we    = 1'b1;
          cap_waddr = idx_q;
          if (idx_q == len_q - LW'(1)) state_d = S_NEXT;
          else                         idx_d   = idx_q + LW'(1);
        end
      end
      S_NEXT: begin
        shot_d = shot_q + 16'd1;
        if (shot_q + 16'd1 < nshot_q) begin
          state_d = S_ARM;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cap_we && mm_hit && (mm_q != '1)) mm_d = mm_q + 32'd1;
    if (state_q != S_IDLE && apg_dbg_error != '0) err_d[3] = 1'b1;

    // An abort in CLEAR already has the APG clear on the bus; a second pulse would be back-to-back.
    if (state_q != S_IDLE && (abort || tmo)) begin
      state_d = S_IDLE;
      kclr_d  = (state_q != S_CLEAR);
      shot_d  = shot_q;
      done_d  = done_q;
      if (abort) err_d[2] = 1'b1;
      else       err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      ph_q     <= 1'b0;
      nshot_q  <= '0;
      shot_q   <= '0;
      wcnt_q   <= '0;
      mm_q     <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      kclr_q   <= 1'b0;
      pat_rd_q <= '0;
      cap_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      ph_q     <= ph_d;
      nshot_q  <= nshot_d;
      shot_q   <= shot_d;
      wcnt_q   <= wcnt_d;
      mm_q     <= mm_d;
      err_q    <= err_d;
      done_q   <= done_d;
      kclr_q   <= kclr_d;
      if (state_q != S_IDLE)
        pat_rd_q <= (32'(rd_addr) < 32'(NUM_SAMP)) ? stage_mem[rd_addr[SW-1:0]] : '0;
      cap_rd_q <= (32'(cap_rd_addr) < 32'(NUM_SAMP)) ? cap_mem[cap_rd_addr[SW-1:0]] : '0;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (pat_wr_en && !busy && 32'(pat_wr_addr) < 32'(NUM_SAMP))
      stage_mem[pat_wr_addr[SW-1:0]] <= pat_wr_data;
    if (cap_we)
      cap_mem[cap_waddr[SW-1:0]] <= apg_read_channel;
  end

  assign busy                       = (state_q != S_IDLE);
  assign done                       = done_q;
  assign shot_count                 = shot_q;
  assign mismatch_count             = mm_q;
  assign err_flags                  = err_q;
  assign cap_rd_data                = cap_rd_q;
  assign apg_run                    = (state_q == S_ARM);
  assign apg_clear                  = (state_q == S_CLEAR) || kclr_q;
  assign apg_n_samples              = 32'(len_q);
  assign apg_write_channel          = pat_rd_q;
  assign apg_write_channel_wrStrobe = (state_q == S_LOAD) && !ph_q;
  assign apg_read_channel_rdStrobe  = (state_q == S_DRAIN) && !ph_q;
endmodule

// File: tb/tb_apg_shot_sequencer.sv
// Bench for apg_shot_sequencer: loopback APG responder, per-cycle protocol/data checker
// and directed runs with hand-computed results.
module tb_apg_shot_sequencer;
  localparam int NS = 14, NSAMP = 128, AW = 8;

  logic gclk = 1'b0, rstn = 1'b0;
  always #5 gclk = ~gclk;

  logic          start = 0, abort = 0, pat_wr_en = 0;
  logic [31:0]   n_samples_cfg = 0, timeout_cycles = 0, apg_dbg_error = 0;
  logic [15:0]   n_shots = 0;
  logic [NS-1:0] compare_mask = 0, pat_wr_data = 0;
  logic [AW-1:0] pat_wr_addr = 0, cap_rd_addr = 0;
  logic [NS-1:0] cap_rd_data, apg_write_channel, apg_read_channel;
  logic          busy, done, apg_run, apg_clear, wr_stb, rd_stb;
  logic [15:0]   shot_count;
  logic [31:0]   mismatch_count, apg_n_samples;
  logic [3:0]    err_flags;
  logic [2:0]    apg_status;

  apg_shot_sequencer #(.NUM_SIG(NS), .NUM_SAMP(NSAMP), .AW(AW)) dut (
    .axi_clk(gclk), .axi_resetn(rstn), .start(start), .abort(abort),
    .n_samples_cfg(n_samples_cfg), .n_shots(n_shots), .timeout_cycles(timeout_cycles),
    .compare_mask(compare_mask), .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr),
    .pat_wr_data(pat_wr_data), .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap_rd_data),
    .busy(busy), .done(done), .shot_count(shot_count), .mismatch_count(mismatch_count),
    .err_flags(err_flags), .apg_run(apg_run), .apg_clear(apg_clear),
    .apg_n_samples(apg_n_samples), .apg_write_channel(apg_write_channel),
    .apg_write_channel_wrStrobe(wr_stb), .apg_read_channel_rdStrobe(rd_stb),
    .apg_read_channel(apg_read_channel), .apg_status(apg_status),
    .apg_dbg_error(apg_dbg_error));

  int nvec = 0, nmis = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Host-side view of the staging RAM, and knobs for the APG responder.
  logic [NS-1:0] pat_m [NSAMP];
  logic [NS-1:0] stuck = 0;
  logic          hang = 0;
  logic [15:0]   exp_nshot = 0;

  // Loopback APG: write buffer feeds the read buffer; status walks TRANSACTION -> DONE -> IDLE.
  logic [NS-1:0] wbuf [NSAMP];
  logic [7:0]    wptr, rptr;
  logic          pend;
  int            tcnt;
  assign apg_read_channel = ((rptr < 8'(NSAMP)) ? wbuf[rptr[6:0]] : '0) & ~stuck;

  always @(negedge gclk or negedge rstn) begin
    if (!rstn) begin
      wptr <= 0; rptr <= 0; pend <= 0; apg_status <= 3'b000; tcnt <= 0;
    end else begin
      pend <= wr_stb;
      if (pend && wptr < 8'(NSAMP)) begin
        wbuf[wptr[6:0]] <= apg_write_channel;
        wptr <= wptr + 8'd1;
      end
      if (apg_clear) begin wptr <= 0; pend <= 0; end
      if (rd_stb) rptr <= rptr + 8'd1;
      if (apg_run) begin
        apg_status <= 3'b101; tcnt <= 0; rptr <= 0;
      end else if (apg_status == 3'b101 && !hang) begin
        if (tcnt == 4) begin apg_status <= 3'b110; tcnt <= 0; end
        else tcnt <= tcnt + 1;
      end else if (apg_status == 3'b110) begin
        if (tcnt == 2) apg_status <= 3'b000;
        else tcnt <= tcnt + 1;
      end
    end
  end

  // Per-cycle checker: pulse shape, write order/data/spacing, event counts.
  int cyc, cnt_wr, cnt_rd, cnt_run, cnt_clr, run_cyc, clr_cyc, last_wr;
  logic [7:0] wr_idx;
  logic p_wr, p_rd, p_run, p_clr;
  always @(negedge gclk or negedge rstn) begin
    if (!rstn) begin
      cyc <= 0; cnt_wr <= 0; cnt_rd <= 0; cnt_run <= 0; cnt_clr <= 0;
      run_cyc <= 0; clr_cyc <= 0; last_wr <= -1; wr_idx <= 0;
      p_wr <= 0; p_rd <= 0; p_run <= 0; p_clr <= 0;
    end else begin
      cyc <= cyc + 1;
      if (wr_stb) begin
        chk("wr_back_to_back", 32'(p_wr), 0);
        chk("wr_data", 32'(apg_write_channel), 32'(pat_m[wr_idx[6:0]]));
        if (last_wr >= 0) chk("wr_spacing", 32'(cyc - last_wr), 2);
        wr_idx <= wr_idx + 8'd1; last_wr <= cyc; cnt_wr <= cnt_wr + 1;
      end
      if (p_wr) chk("wr_hold", 32'(apg_write_channel), 32'(pat_m[7'(wr_idx - 8'd1)]));
      if (rd_stb) begin chk("rd_back_to_back", 32'(p_rd), 0); cnt_rd <= cnt_rd + 1; end
      if (apg_run) begin
        chk("run_back_to_back", 32'(p_run), 0); cnt_run <= cnt_run + 1; run_cyc <= cyc;
      end
      if (apg_clear) begin
        chk("clr_back_to_back", 32'(p_clr), 0); cnt_clr <= cnt_clr + 1; clr_cyc <= cyc;
        wr_idx <= 0; last_wr <= -1;
      end
      if (busy) begin
        chk("dbg_err_flag", 32'(err_flags[3]), 0);
        chk("shot_bound", 32'(shot_count <= exp_nshot), 1);
      end
      p_wr <= wr_stb; p_rd <= rd_stb; p_run <= apg_run; p_clr <= apg_clear;
    end
  end

  function automatic int exp_mm(input int L, input int ne, input logic [NS-1:0] m,
                                input logic [NS-1:0] s);
    int c = 0;
    for (int i = 0; i < L; i++) if ((pat_m[7'(i)] & s & m) != '0) c++;
    return c * ne;
  endfunction

  task automatic pat_write(input int a, input logic [NS-1:0] d, input bit track);
    @(negedge gclk);
    pat_wr_en = 1; pat_wr_addr = AW'(a); pat_wr_data = d;
    if (track) pat_m[7'(a)] = d;
    @(negedge gclk);
    pat_wr_en = 0;
  endtask

  task automatic start_run(input int ns, input int nsh, input int to, input logic [NS-1:0] m);
    @(negedge gclk);
    n_samples_cfg = ns; n_shots = 16'(nsh); timeout_cycles = to; compare_mask = m;
    exp_nshot = (nsh == 0) ? 16'd1 : 16'(nsh);
    start = 1;
    @(negedge gclk);
    start = 0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge gclk);
    chk("idle_within_budget", 32'(busy), 0);
    repeat (2) @(negedge gclk);
  endtask

  task automatic cap_read(input int a, input logic [NS-1:0] exp);
    @(negedge gclk);
    cap_rd_addr = AW'(a);
    @(negedge gclk);
    chk($sformatf("capture[%0d]", a), 32'(cap_rd_data), 32'(exp));
  endtask

  task automatic full_run(input int cfgL, input int nsh, input logic [NS-1:0] m,
                          input logic [NS-1:0] stk, input logic [3:0] exp_err);
    int L, ne, b_wr, b_rd, b_run, b_clr;
    L = (cfgL > NSAMP) ? NSAMP : cfgL;
    ne = (nsh == 0) ? 1 : nsh;
    stuck = stk;
    b_wr = cnt_wr; b_rd = cnt_rd; b_run = cnt_run; b_clr = cnt_clr;
    start_run(cfgL, nsh, 0, m);
    chk("busy_after_start", 32'(busy), 1);
    chk("done_cleared_by_start", 32'(done), 0);
    chk("apg_n_samples", apg_n_samples, 32'(L));
    wait_idle(4000);
    chk("done", 32'(done), 1);
    chk("shot_count", 32'(shot_count), 32'(ne));
    chk("mismatch_model", mismatch_count, 32'(exp_mm(L, ne, m, stk)));
    chk("err_flags", 32'(err_flags), 32'(exp_err));
    chk("wr_strobes", 32'(cnt_wr - b_wr), 32'(L));
    chk("run_pulses", 32'(cnt_run - b_run), 32'(ne));
    chk("rd_strobes", 32'(cnt_rd - b_rd), 32'(ne * (L - 1)));
    chk("clear_pulses", 32'(cnt_clr - b_clr), 1);
    for (int i = 0; i < L; i++)
      if (L <= 8 || i % 37 == 0 || i == L - 1) cap_read(i, pat_m[7'(i)] & ~stk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);        chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_shot"}, 32'(shot_count), 0);  chk({tag, "_mm"}, mismatch_count, 0);
    chk({tag, "_err"}, 32'(err_flags), 0);    chk({tag, "_run"}, 32'(apg_run), 0);
    chk({tag, "_clr"}, 32'(apg_clear), 0);    chk({tag, "_nsamp"}, apg_n_samples, 0);
    chk({tag, "_wch"}, 32'(apg_write_channel), 0);
    chk({tag, "_wstb"}, 32'(wr_stb), 0);      chk({tag, "_rstb"}, 32'(rd_stb), 0);
    chk({tag, "_cap"}, 32'(cap_rd_data), 0);
  endtask

  task automatic do_reset();
    @(negedge gclk); rstn = 0;
    repeat (3) @(negedge gclk);
    rstn = 1;
    @(negedge gclk);
  endtask

  initial begin
    int n, b_rd, b_clr;
    for (int i = 0; i < NSAMP; i++) pat_m[i] = '0;
    repeat (3) @(negedge gclk);
    chk_all_zero("reset");
    rstn = 1;

    // Clean loopback, L=4, pattern 1..4
    for (int i = 0; i < 4; i++) pat_write(i, NS'(i + 1), 1);
    full_run(4, 1, '1, '0, 4'b0000);
    chk("clean_mm_literal", mismatch_count, 0);
    chk("clean_shot_literal", 32'(shot_count), 1);
    cap_read(2, 14'd3);

    // n_shots=0 acts as 1; a host write while busy must not land
    start_run(4, 0, 0, '1);
    pat_write(0, 14'h3FFF, 0);
    wait_idle(2000);
    chk("nshots0_shot", 32'(shot_count), 1);
    cap_read(0, 14'd1);

    // Three shots, input bit 0 stuck low, pattern all 0x0001
    for (int i = 0; i < 8; i++) pat_write(i, 14'h0001, 1);
    full_run(8, 3, '1, 14'h0001, 4'b0000);
    chk("stuck_mm_literal", mismatch_count, 24);
    full_run(8, 3, 14'h3FFE, 14'h0001, 4'b0000);
    chk("masked_mm_literal", mismatch_count, 0);

    // Zero length refused; oversize clamps to the buffer depth
    start_run(0, 1, 0, '1);
    chk("cfg0_busy", 32'(busy), 0);
    chk("cfg0_err", 32'(err_flags), 1);
    for (int i = 0; i < NSAMP; i++) pat_write(i, NS'((i * 37 + 5) & 16'h3FFF), 1);
    full_run(500, 1, '1, '0, 4'b0001);
    cap_read(200, 14'd0);

    // Timeout in WAIT_DONE after exactly 50 cycles
    do_reset();
    chk("err_after_reset", 32'(err_flags), 0);
    hang = 1;
    b_clr = cnt_clr;
    start_run(4, 1, 50, '1);
    wait_idle(500);
    chk("tmo_run_to_clear", 32'(clr_cyc - run_cyc), 51);
    chk("tmo_err", 32'(err_flags), 32'b0010);
    chk("tmo_done", 32'(done), 0);
    chk("tmo_clear_pulses", 32'(cnt_clr - b_clr), 2);
    hang = 0;
    do_reset();

    // Abort on the strobe for sample 3 of DRAIN
    for (int i = 0; i < 8; i++) pat_write(i, NS'(16'h0100 + 16'(i)), 1);
    stuck = '0;
    b_rd = cnt_rd;
    start_run(8, 1, 0, '1);
    pat_write(0, 14'h3FFF, 0);
    n = 0;
    for (int k = 0; k < 500 && n < 3; k++) begin
      @(negedge gclk);
      if (rd_stb) n++;
    end
    chk("abort_reached_sample3", 32'(n), 3);
    abort = 1;
    @(negedge gclk);
    abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_clear", 32'(apg_clear), 1);
    chk("abort_err", 32'(err_flags), 32'b0100);
    chk("abort_shot", 32'(shot_count), 0);
    chk("abort_done", 32'(done), 0);
    repeat (20) @(negedge gclk);
    chk("abort_no_more_rd", 32'(cnt_rd - b_rd), 3);
    full_run(8, 1, '1, '0, 4'b0000);

    // start+abort together in IDLE: nothing happens
    b_clr = cnt_clr;
    @(negedge gclk); n_samples_cfg = 4; start = 1; abort = 1;
    @(negedge gclk); start = 0; abort = 0;
    chk("startabort_busy", 32'(busy), 0);
    chk("startabort_err", 32'(err_flags), 0);
    repeat (3) @(negedge gclk);
    chk("startabort_no_clear", 32'(cnt_clr - b_clr), 0);

    // Reset in the middle of LOAD
    start_run(8, 2, 0, '1);
    repeat (5) @(negedge gclk);
    rstn = 0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge gclk);
    rstn = 1;
    repeat (2) @(negedge gclk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
